// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline register: state encoding,
// default payload width and the state-to-occupancy decode.
package pipe_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_e;

    function automatic logic [1:0] occ_of(input state_e s);
        case (s)
            ONE:     return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/data_reg_en.sv
// N-bit data register with load enable and asynchronous active-low reset to
// a parameterised value.
module data_reg_en
    import pipe_pkg::*;
#(
    parameter int            N         = XLEN,
    parameter logic [N-1:0]  RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register: full throughput with in_ready
// decoded purely from registered state, never from out_ready.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int            N         = XLEN,
    parameter logic [N-1:0]  RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [1:0]   occupancy
);

    if (N < 1 || N > 128) begin : g_bad_width
        $error("pipe_skid_reg: N must be in 1..128");
    end

    state_e       state_q;
    state_e       state_d;
    logic         accept;
    logic         emit;
    logic         main_en;
    logic         skid_en;
    logic [N-1:0] main_d;
    logic [N-1:0] skid_d;
    logic [N-1:0] main_q;
    logic [N-1:0] skid_q;

    // Handshake outputs come straight from the state register.
    always_comb begin
        out_valid = (state_q != EMPTY);
        in_ready  = (state_q != FULL);
        occupancy = occ_of(state_q);
        out_data  = main_q;
    end

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = in_data;
        skid_d  = in_data;
        if (flush) begin
            // Flush wins: any same-cycle accept is dropped.
            state_d = EMPTY;
            main_en = 1'b1;
            skid_en = 1'b1;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_en = 1'b1;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        main_en = 1'b1;
                    end else if (accept) begin
                        skid_en = 1'b1;
                        state_d = FULL;
                    end else if (emit) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (emit) begin
                        main_en = 1'b1;
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    data_reg_en #(
        .N         (N),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    data_reg_en #(
        .N         (N),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (skid_d),
        .q   (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomised bench for pipe_skid_reg with a queue reference model
// driving a 64-bit and an 8-bit instance.
module tb_pipe_skid_reg;

    localparam logic [63:0] RV_A = 64'hDEAD_BEEF_0000_0001;
    localparam logic [7:0]  RV_B = 8'h5A;

    logic        clk;
    logic        rst;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [63:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_in_data, b_out_data;
    logic [1:0]  b_occ;

    logic [63:0] qa[$];
    logic [7:0]  qb[$];

    int total = 0;
    int bad   = 0;

    pipe_skid_reg #(.N(64), .RESET_VAL(RV_A)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .flush     (a_flush),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .occupancy (a_occ)
    );

    pipe_skid_reg #(.N(8), .RESET_VAL(RV_B)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .flush     (b_flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .occupancy (b_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Apply inputs for the coming edge and advance the model by that edge.
    task automatic set_a(input logic fl, input logic iv, input logic [63:0] d, input logic ordy);
        bit acc, emt;
        a_flush = fl; a_in_valid = iv; a_in_data = d; a_out_ready = ordy;
        acc = iv && (qa.size() < 2);
        emt = ordy && (qa.size() > 0);
        if (fl) qa.delete();
        else begin
            if (emt) void'(qa.pop_front());
            if (acc) qa.push_back(d);
        end
    endtask

    task automatic set_b(input logic fl, input logic iv, input logic [7:0] d, input logic ordy);
        bit acc, emt;
        b_flush = fl; b_in_valid = iv; b_in_data = d; b_out_ready = ordy;
        acc = iv && (qb.size() < 2);
        emt = ordy && (qb.size() > 0);
        if (fl) qb.delete();
        else begin
            if (emt) void'(qb.pop_front());
            if (acc) qb.push_back(d);
        end
    endtask

    task automatic step_a(input logic fl, input logic iv, input logic [63:0] d, input logic ordy);
        set_a(fl, iv, d, ordy);
        @(negedge clk);
    endtask

    task automatic model_a();
        check("a_valid", {63'd0, a_out_valid}, {63'd0, qa.size() > 0});
        check("a_occ", {62'd0, a_occ}, 64'(qa.size()));
        check("a_ready_occ", {63'd0, a_in_ready}, {63'd0, a_occ < 2'd2});
        if (qa.size() > 0) check("a_data", a_out_data, qa[0]);
    endtask

    task automatic model_b();
        check("b_valid", {63'd0, b_out_valid}, {63'd0, qb.size() > 0});
        check("b_occ", {62'd0, b_occ}, 64'(qb.size()));
        check("b_ready_occ", {63'd0, b_in_ready}, {63'd0, b_occ < 2'd2});
        if (qb.size() > 0) check("b_data", {56'd0, b_out_data}, {56'd0, qb[0]});
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_valid"}, {63'd0, a_out_valid}, 64'd0);
        check({tag, "_ready"}, {63'd0, a_in_ready}, 64'd1);
        check({tag, "_occ"}, {62'd0, a_occ}, 64'd0);
        check({tag, "_data"}, a_out_data, RV_A);
    endtask

    initial begin
        rst = 1'b0;
        a_flush = 0; a_in_valid = 1; a_in_data = 64'h1234; a_out_ready = 1;
        b_flush = 0; b_in_valid = 1; b_in_data = 8'h77;    b_out_ready = 1;
        repeat (3) @(negedge clk);

        // Reset held with inputs active: nothing may be accepted.
        check_idle_a("rst_a");
        check("rst_b_valid", {63'd0, b_out_valid}, 64'd0);
        check("rst_b_occ", {62'd0, b_occ}, 64'd0);
        check("rst_b_data", {56'd0, b_out_data}, {56'd0, RV_B});

        set_b(0, 0, 8'h00, 0);
        rst = 1'b1;
        step_a(0, 1, 64'hA5A5_A5A5, 0);
        check("first_valid", {63'd0, a_out_valid}, 64'd1);
        check("first_data", a_out_data, 64'hA5A5_A5A5);
        check("first_occ", {62'd0, a_occ}, 64'd1);
        step_a(0, 0, 64'd0, 1);
        model_a();

        // Streaming 1..100 at full rate.
        for (int i = 1; i <= 100; i++) begin
            step_a(0, 1, 64'(i), 1);
            check("stream_data", a_out_data, 64'(i));
            check("stream_occ", {62'd0, a_occ}, 64'd1);
        end
        step_a(0, 0, 64'd0, 1);
        model_a();

        // Backpressure fills the skid and holds the head stable.
        step_a(0, 1, 64'h11, 0);
        check("bp_occ1", {62'd0, a_occ}, 64'd1);
        step_a(0, 1, 64'h22, 0);
        check("bp_occ2", {62'd0, a_occ}, 64'd2);
        check("bp_ready0", {63'd0, a_in_ready}, 64'd0);
        check("bp_head", a_out_data, 64'h11);
        step_a(0, 1, 64'h99, 0);
        check("bp_stable", a_out_data, 64'h11);
        check("bp_occ_hold", {62'd0, a_occ}, 64'd2);
        step_a(0, 0, 64'd0, 1);
        check("bp_second", a_out_data, 64'h22);
        check("bp_ready1", {63'd0, a_in_ready}, 64'd1);
        check("bp_occ_after", {62'd0, a_occ}, 64'd1);
        step_a(0, 0, 64'd0, 1);
        check("bp_drained", {63'd0, a_out_valid}, 64'd0);

        // Flush in FULL with a same-cycle offer that must be dropped.
        step_a(0, 1, 64'h44, 0);
        step_a(0, 1, 64'h55, 0);
        step_a(1, 1, 64'h33, 0);
        check_idle_a("flush");
        for (int i = 0; i < 3; i++) begin
            step_a(0, 0, 64'd0, 1);
            check("flush_no33", {63'd0, a_out_valid}, 64'd0);
        end
        step_a(1, 0, 64'd0, 0);
        check_idle_a("flush_empty");

        // Asynchronous reset between edges while FULL.
        step_a(0, 1, 64'h66, 0);
        step_a(0, 1, 64'h77, 0);
        check("pre_rst_occ", {62'd0, a_occ}, 64'd2);
        #2 rst = 1'b0;
        #1;
        check_idle_a("async_rst");
        qa.delete();
        qb.delete();
        @(negedge clk);
        set_a(0, 0, 64'd0, 1);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_empty", {63'd0, a_out_valid}, 64'd0);
        step_a(0, 1, 64'h88, 1);
        check("post_rst_data", a_out_data, 64'h88);
        step_a(0, 0, 64'd0, 1);
        model_a();

        // Random valid/ready/flush on both widths against the queue model.
        for (int c = 0; c < 10000; c++) begin
            set_a($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                  {$urandom, $urandom}, $urandom_range(0, 2) != 0);
            set_b($urandom_range(0, 63) == 0, $urandom_range(0, 1) != 0,
                  8'($urandom), $urandom_range(0, 3) != 0);
            @(negedge clk);
            model_a();
            model_b();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-002 Parameter N, default 32: payload width in bits, legal range 1..128.
REQ-003 Parameter RESET_VAL, default 0: N-bit value loaded into both data registers on reset and on flush.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous reset, active-low.
REQ-006 flush  input  1  synchronous discard of all held entries.
REQ-007 in_valid  input  1  upstream payload present.
REQ-008 in_ready  output  1  block can accept; registered, not combinational from out_ready.
REQ-009 in_data  input  N  upstream payload.
REQ-010 out_valid  output  1  out_data holds a valid entry.
REQ-011 out_ready  input  1  downstream accepts.
REQ-012 out_data  output  N  oldest held entry.
REQ-013 occupancy  output  2  number of held entries, 0..2.

Function
REQ-014 Accept SHALL be defined as in_valid & in_ready, and emit as out_valid & out_ready, both sampled at the rising clk edge.
REQ-015 The block SHALL hold a main register and a skid register, and SHALL implement states EMPTY (0 entries), ONE (main valid) and FULL (main and skid valid).
REQ-016 Outputs SHALL decode from state as follows: out_valid = (state != EMPTY); in_ready = (state != FULL); occupancy = 0/1/2 for EMPTY/ONE/FULL; out_data = main at all times.
REQ-017 In EMPTY, an accept SHALL load main with in_data and move to ONE; otherwise the block SHALL stay in EMPTY.
REQ-018 In ONE, accept plus emit SHALL load main with in_data and stay in ONE.
REQ-019 In ONE, accept without emit SHALL load skid with in_data and move to FULL.
REQ-020 In ONE, emit without accept SHALL move to EMPTY.
REQ-021 In ONE, with neither accept nor emit, the block SHALL stay in ONE.
REQ-022 In FULL, an emit SHALL copy skid into main and move to ONE; otherwise the block SHALL stay in FULL; no accept is possible in FULL.
REQ-023 Latency SHALL be one cycle: data accepted at edge k SHALL appear on out_data with out_valid=1 after edge k, provided it is the oldest entry.
REQ-024 Sustained throughput SHALL be one transfer per cycle whenever in_valid and out_ready are both continuously high.
REQ-025 Ordering SHALL be strict FIFO, with no loss and no duplication.
REQ-026 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-027 Data registers SHALL change only on accept, on FULL->ONE promotion, on flush or on reset.
REQ-028 Flush SHALL take priority over accept and emit: next state EMPTY, main and skid set to RESET_VAL, and any same-cycle accept discarded.
REQ-029 An emit in the flush cycle SHALL count as delivered downstream; the upstream side SHALL treat any accept in that cycle as dropped.
REQ-030 Flush asserted in EMPTY SHALL be harmless: state stays EMPTY and registers hold RESET_VAL.
REQ-031 Width rules: in_data and out_data SHALL be exactly N bits, with no truncation or extension.

Reset
REQ-032 On rst=0 the block SHALL, immediately and regardless of clk, set state to EMPTY, main and skid to RESET_VAL, out_valid=0, in_ready=1 and occupancy=0.
REQ-033 Assertion of rst mid-operation SHALL drop all held entries, with no partial transfer completed.
REQ-034 Inputs SHALL be ignored while rst=0; the first accept SHALL be possible at the first rising edge after deassertion.

Structure
REQ-035 Shared package pipe_pkg SHALL contain the state encoding (EMPTY=2'b00, ONE=2'b01, FULL=2'b10) and the default width constant XLEN=32.
REQ-036 Sub-module data_reg_en (N-bit register with load enable and asynchronous active-low reset to RESET_VAL) SHALL be instantiated twice, once for main and once for skid.
REQ-037 Unused state encoding 2'b11 SHALL recover to EMPTY on the next edge.

Verification
REQ-038 Reset: hold rst=0 and toggle clk -> out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VAL; deassert, present 0xA5A5A5A5 -> out_data=0xA5A5A5A5, out_valid=1 after one edge.
REQ-039 Streaming: in_valid=1 and out_ready=1 with values 1..100 -> out_data yields 1..100 in order, one per cycle, occupancy constant at 1.
REQ-040 Backpressure: out_ready=0, send 0x11 then 0x22 -> occupancy=2, in_ready=0, out_data=0x11 stable; raise out_ready -> 0x11 then 0x22 emitted, and in_ready=1 one cycle after the first emit.
REQ-041 Flush in FULL with same-cycle in_valid=1 (0x33) -> next cycle state EMPTY, out_valid=0, and 0x33 never emitted.
REQ-042 Asynchronous reset mid-stream: assert rst between edges while FULL -> outputs return to reset values before the next edge, and the old data never reappears.
REQ-043 Random valid/ready (10k cycles, N=8 and N=64) against a reference queue model -> no loss or reorder, in_ready==(occupancy<2) every cycle.
